// File: rtl/common_pkg.sv
// Shared data-bus types, access-size encodings and the MEM stage state set.
// Pure type/constant package: no latency.
// No flow control of its own; the types carry valid/ok handshakes.
package common;

    // Access size encodings (log2 of the byte count).
    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    // True when the low address bits are not a multiple of the access size.
    function automatic logic misaligned(input logic [2:0] off, input logic [1:0] sz);
        logic m;
        case (sz)
            SZ_BYTE: m = 1'b0;
            SZ_HALF: m = off[0];
            SZ_WORD: m = |off[1:0];
            default: m = |off;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/pipes_pkg.sv
// Pipeline register payloads on either side of the MEM stage.
// Pure type package: no latency.
// Flow control is carried by the valid bit and the stage stall signals.
package pipes;

    typedef struct packed {
        logic        valid;
        logic        is_load;
        logic        is_store;
        logic [1:0]  size;
        logic        sign_ext;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] pc;
        logic [4:0]  rd;
    } execute_data_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] rdata;
        logic        exc_misalign;
        logic [63:0] pc;
        logic [4:0]  rd;
    } memory_data_t;

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering: store strobe/data placement and load extract/extend.
// Latency: purely combinational.
// No backpressure; outputs follow inputs.
module mem_align (
    input  logic [2:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata_raw,
    output logic [7:0]  strobe,
    output logic [63:0] wdata_sh,
    output logic [63:0] rdata
);

    logic [7:0]  size_mask;
    logic [63:0] rd_sh;

    // Place store bytes on their lanes and pull load bytes down to bit 0.
    always_comb begin
        case (size)
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
        strobe   = size_mask << addr_lo;
        wdata_sh = wdata << {addr_lo, 3'b000};
        rd_sh    = rdata_raw >> {addr_lo, 3'b000};
        case (size)
            2'd0:    rdata = sign_ext ? {{56{rd_sh[7]}},  rd_sh[7:0]}  : {56'd0, rd_sh[7:0]};
            2'd1:    rdata = sign_ext ? {{48{rd_sh[15]}}, rd_sh[15:0]} : {48'd0, rd_sh[15:0]};
            2'd2:    rdata = sign_ext ? {{32{rd_sh[31]}}, rd_sh[31:0]} : {32'd0, rd_sh[31:0]};
            default: rdata = rd_sh;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores on the data bus, returns aligned results.
// Latency: 0 cycles for non-memory ops; memory ops complete in the data_ok cycle.
// Backpressure: stall_o holds EX/MEM while a bus access or an unaccepted result is pending.
// Optional feature macro MEM_MISALIGN_EXC_EN: misaligned accesses raise exc_misalign instead of issuing.
module mem_stage
    import common::*, pipes::*;
(
    input  logic          clk,
    input  logic          rst,
    input  execute_data_t dataE_nxt,
    input  logic          flush,
    input  logic          stall_i,
    output dbus_req_t     dreq,
    input  dbus_resp_t    dresp,
    output memory_data_t  dataM,
    output logic          stall_o
);

    mem_state_t    state_q, state_d;
    logic          kill_q, kill_d;
    memory_data_t  res_q, res_d;
    execute_data_t ex_q, ex_d;

    execute_data_t cur;
    memory_data_t  res;
    logic          is_mem;
    logic          misalign;
    logic          req_vld;
    logic [7:0]    al_strobe;
    logic [63:0]   al_wdata;
    logic [63:0]   al_rdata;

    // Sequencing uses data_ok only; the address handshake is not needed.
    logic unused_addr_ok;
    assign unused_addr_ok = dresp.addr_ok;

    mem_align u_align (
        .addr_lo   (cur.addr[2:0]),
        .size      (cur.size),
        .sign_ext  (cur.sign_ext),
        .wdata     (cur.wdata),
        .rdata_raw (dresp.data),
        .strobe    (al_strobe),
        .wdata_sh  (al_wdata),
        .rdata     (al_rdata)
    );

    // While waiting, drive the bus from the captured copy so fields cannot drift.
    always_comb begin
        cur    = (state_q == WAIT) ? ex_q : dataE_nxt;
        is_mem = cur.valid & (cur.is_load | cur.is_store);
`ifdef MEM_MISALIGN_EXC_EN
        misalign = is_mem & misaligned(cur.addr[2:0], cur.size);
`else
        misalign = 1'b0;
`endif
        res              = '0;
        res.valid        = 1'b1;
        res.rdata        = cur.is_load ? al_rdata : 64'd0;
        res.exc_misalign = 1'b0;
        res.pc           = cur.pc;
        res.rd           = cur.rd;
    end

    // Stage FSM: next state, bus request, result and stall generation.
    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        res_d   = res_q;
        ex_d    = ex_q;
        req_vld = 1'b0;
        dataM   = '0;
        stall_o = 1'b0;
        dreq    = '0;

        case (state_q)
            IDLE: begin
                if (!flush && dataE_nxt.valid) begin
                    if (!is_mem) begin
                        dataM = res;
                    end else if (misalign) begin
                        dataM              = res;
                        dataM.rdata        = 64'd0;
                        dataM.exc_misalign = 1'b1;
                    end else begin
                        req_vld = 1'b1;
                        stall_o = 1'b1;
                        ex_d    = dataE_nxt;
                        if (dresp.data_ok) begin
                            if (stall_i) begin
                                res_d   = res;
                                state_d = DONE;
                            end else begin
                                dataM   = res;
                                stall_o = 1'b0;
                            end
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                req_vld = 1'b1;
                stall_o = 1'b1;
                kill_d  = kill_q | flush;
                if (dresp.data_ok) begin
                    kill_d  = 1'b0;
                    stall_o = 1'b0;
                    state_d = IDLE;
                    if (!(kill_q | flush)) begin
                        if (stall_i) begin
                            res_d   = res;
                            stall_o = 1'b1;
                            state_d = DONE;
                        end else begin
                            dataM = res;
                        end
                    end
                end
            end
            DONE: begin
                dataM   = res_q;
                stall_o = 1'b1;
                if (flush) begin
                    dataM   = '0;
                    stall_o = 1'b0;
                    state_d = IDLE;
                end else if (!stall_i) begin
                    stall_o = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (req_vld) begin
            dreq.valid  = 1'b1;
            dreq.addr   = cur.addr;
            dreq.size   = {1'b0, cur.size};
            dreq.strobe = cur.is_store ? al_strobe : 8'h00;
            dreq.data   = cur.is_store ? al_wdata : 64'd0;
        end

        if (rst) begin
            dreq    = '0;
            dataM   = '0;
            stall_o = 1'b0;
        end
    end

    // State registers with synchronous reset; reset abandons any bus access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            kill_q  <= 1'b0;
            res_q   <= '0;
            ex_q    <= '0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            res_q   <= res_d;
            ex_q    <= ex_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage against a byte-level reference model.
// Latency: drives one transaction at a time and checks every cycle.
// Backpressure: exercises stall_i, flush and reset in the waiting states.
module tb_mem_stage;
    import common::*;
    import pipes::*;

    logic          clk = 1'b0;
    logic          rst;
    execute_data_t ex;
    logic          flush;
    logic          stall_i;
    dbus_req_t     dreq;
    dbus_resp_t    dresp;
    memory_data_t  dataM;
    logic          stall_o;

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .clk       (clk),
        .rst       (rst),
        .dataE_nxt (ex),
        .flush     (flush),
        .stall_i   (stall_i),
        .dreq      (dreq),
        .dresp     (dresp),
        .dataM     (dataM),
        .stall_o   (stall_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (byte arithmetic) ----------------
    function automatic int nbytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic logic m_misal(input logic [63:0] a, input logic [1:0] sz);
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [7:0] m_strobe(input logic [63:0] a, input logic [1:0] sz);
        logic [7:0] s = 8'h00;
        int off = int'(a % 8);
        for (int i = 0; i < nbytes(sz); i++)
            if (off + i < 8) s[off + i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] a, input logic [63:0] w);
        logic [63:0] o = 64'd0;
        int off = int'(a % 8);
        for (int b = off; b < 8; b++) o[b*8 +: 8] = w[(b-off)*8 +: 8];
        return o;
    endfunction

    function automatic logic [63:0] m_rdata(input logic [63:0] d, input logic [63:0] a,
                                            input logic [1:0] sz, input logic sx);
        logic [63:0] v = 64'd0;
        int off = int'(a % 8);
        int n = nbytes(sz);
        for (int i = 0; i < n; i++)
            if (off + i < 8) v[i*8 +: 8] = d[(off+i)*8 +: 8];
        if (sx && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
        return v;
    endfunction

    function automatic execute_data_t rand_ex(input logic ld, input logic align);
        execute_data_t r;
        r.valid    = 1'b1;
        r.is_load  = ld;
        r.is_store = !ld;
        r.size     = 2'($urandom);
        r.sign_ext = 1'($urandom);
        r.addr     = {$urandom, $urandom};
        if (align) r.addr = r.addr & ~((64'd1 << r.size) - 64'd1);
        r.wdata    = {$urandom, $urandom};
        r.pc       = {$urandom, $urandom};
        r.rd       = 5'($urandom);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex      = '0;
        flush   = 1'b0;
        stall_i = 1'b0;
        dresp   = '0;
    endtask

    // One memory transaction: lat cycles before data_ok, sc extra stalled cycles after.
    task automatic do_mem(input execute_data_t e, input int lat, input logic [63:0] rdat,
                          input int sc, input string nm);
        memory_data_t em;
        em = '{valid: 1'b1, rdata: (e.is_load ? m_rdata(rdat, e.addr, e.size, e.sign_ext) : 64'd0),
               exc_misalign: 1'b0, pc: e.pc, rd: e.rd};
        ex = e;
        flush = 1'b0;
`ifdef MEM_MISALIGN_EXC_EN
        if (m_misal(e.addr, e.size)) begin
            stall_i = 1'b0;
            dresp = '0;
            em.rdata = 64'd0;
            em.exc_misalign = 1'b1;
            #1;
            checks++; if (dreq.valid !== 1'b0) begin errors++; $display("FAIL %s misal_dreq got %0b exp 0", nm, dreq.valid); end
            checks++; if (dataM !== em) begin errors++; $display("FAIL %s misal_dataM got %h exp %h", nm, dataM, em); end
            checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL %s misal_stall got %0b exp 0", nm, stall_o); end
            tick();
            ex.valid = 1'b0;
            return;
        end
`endif
        for (int c = 0; c <= lat; c++) begin
            dresp.addr_ok = 1'($urandom);
            dresp.data_ok = (c == lat);
            dresp.data    = (c == lat) ? rdat : {$urandom, $urandom};
            stall_i       = (c == lat) && (sc > 0);
            #1;
            checks++;
            if ({dreq.valid, dreq.addr, dreq.size} !== {1'b1, e.addr, {1'b0, e.size}}) begin
                errors++; $display("FAIL %s req_hdr cyc %0d got %h/%h/%0d exp 1/%h/%0d", nm, c,
                                   dreq.valid, dreq.addr, dreq.size, e.addr, e.size);
            end
            if (e.is_store) begin
                checks++;
                if ({dreq.strobe, dreq.data} !== {m_strobe(e.addr, e.size), m_wdata(e.addr, e.wdata)}) begin
                    errors++; $display("FAIL %s req_st cyc %0d got %h/%h exp %h/%h", nm, c, dreq.strobe,
                                       dreq.data, m_strobe(e.addr, e.size), m_wdata(e.addr, e.wdata));
                end
            end
            if (c < lat) begin
                checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL %s wait_stall cyc %0d got %0b exp 1", nm, c, stall_o); end
                checks++; if (dataM.valid !== 1'b0) begin errors++; $display("FAIL %s wait_vld cyc %0d got %0b exp 0", nm, c, dataM.valid); end
            end else if (sc == 0) begin
                checks++; if (dataM !== em) begin errors++; $display("FAIL %s ok_dataM got %h exp %h", nm, dataM, em); end
                checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL %s ok_stall got %0b exp 0", nm, stall_o); end
            end else begin
                checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL %s ok_hold_stall got %0b exp 1", nm, stall_o); end
            end
            tick();
        end
        dresp.data_ok = 1'b0;
        if (sc > 0) begin
            for (int s = 0; s <= sc; s++) begin
                stall_i    = (s < sc);
                dresp.data = {$urandom, $urandom};
                #1;
                checks++; if (dreq.valid !== 1'b0) begin errors++; $display("FAIL %s done_req got %0b exp 0", nm, dreq.valid); end
                checks++; if (dataM !== em) begin errors++; $display("FAIL %s done_dataM got %h exp %h", nm, dataM, em); end
                checks++; if (stall_o !== (s < sc)) begin errors++; $display("FAIL %s done_stall s %0d got %0b exp %0b", nm, s, stall_o, s < sc); end
                tick();
            end
        end
        ex.valid = 1'b0;
        stall_i  = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ex = rand_ex(1'b1, 1'b1);
            dresp.data_ok = 1'($urandom);
            #1;
            checks++;
            if ({dreq.valid, dataM.valid, stall_o} !== 3'b000) begin
                errors++; $display("FAIL reset_outs got %b exp 000", {dreq.valid, dataM.valid, stall_o});
            end
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if ({dreq.valid, dataM.valid, stall_o} !== 3'b000) begin
            errors++; $display("FAIL reset_idle got %b exp 000", {dreq.valid, dataM.valid, stall_o});
        end
        tick();
    endtask

    task automatic test_passthrough();
        memory_data_t em;
        for (int i = 0; i < 20; i++) begin
            ex = rand_ex(1'b0, 1'b0);
            ex.is_store = 1'b0;
            ex.valid = ($urandom % 4) != 0;
            stall_i = 1'($urandom);
            dresp.data_ok = 1'($urandom);
            em = '{valid: 1'b1, rdata: 64'd0, exc_misalign: 1'b0, pc: ex.pc, rd: ex.rd};
            #1;
            checks++; if ({dreq.valid, stall_o} !== 2'b00) begin errors++; $display("FAIL pass_req_stall got %b exp 00", {dreq.valid, stall_o}); end
            checks++;
            if (ex.valid ? (dataM !== em) : (dataM.valid !== 1'b0)) begin
                errors++; $display("FAIL pass_dataM got %h exp valid=%0b %h", dataM, ex.valid, em);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_directed();
        execute_data_t e;
        e = '{valid: 1'b1, is_load: 1'b1, is_store: 1'b0, size: SZ_BYTE, sign_ext: 1'b1,
              addr: 64'h1003, wdata: 64'd0, pc: 64'h400, rd: 5'd3};
        do_mem(e, 3, 64'h00000000_80000000, 0, "ld_byte_signed");
        e = '{valid: 1'b1, is_load: 1'b0, is_store: 1'b1, size: SZ_HALF, sign_ext: 1'b0,
              addr: 64'h2006, wdata: 64'hBEEF, pc: 64'h404, rd: 5'd0};
        do_mem(e, 2, 64'd0, 0, "st_half");
        e = '{valid: 1'b1, is_load: 1'b1, is_store: 1'b0, size: SZ_DWORD, sign_ext: 1'b0,
              addr: 64'h3000, wdata: 64'd0, pc: 64'h408, rd: 5'd7};
        do_mem(e, 1, 64'h01234567_89ABCDEF, 2, "ld_dword_stall");
        e.addr = 64'h3008;
        do_mem(e, 0, 64'hFEDCBA98_76543210, 0, "ld_dword_ok0");
    endtask

    task automatic test_misalign();
        execute_data_t e;
        e = '{valid: 1'b1, is_load: 1'b1, is_store: 1'b0, size: SZ_WORD, sign_ext: 1'b0,
              addr: 64'h1002, wdata: 64'd0, pc: 64'h500, rd: 5'd9};
        do_mem(e, 1, 64'h11223344_55667788, 0, "ld_word_misal");
    endtask

    task automatic test_flush();
        // Flush while waiting: request held, result discarded.
        ex = rand_ex(1'b1, 1'b1);
        for (int c = 0; c < 4; c++) begin
            flush = (c == 1);
            dresp.data_ok = (c == 3);
            dresp.data = {$urandom, $urandom};
            #1;
            checks++; if (dreq.valid !== 1'b1) begin errors++; $display("FAIL flush_wait_req cyc %0d got %0b exp 1", c, dreq.valid); end
            checks++; if (dataM.valid !== 1'b0) begin errors++; $display("FAIL flush_wait_vld cyc %0d got %0b exp 0", c, dataM.valid); end
            if (c < 3) begin
                checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL flush_wait_stall cyc %0d got %0b exp 1", c, stall_o); end
            end
            tick();
        end
        idle_inputs();
        #1;
        checks++;
        if ({dreq.valid, dataM.valid, stall_o} !== 3'b000) begin
            errors++; $display("FAIL flush_wait_after got %b exp 000", {dreq.valid, dataM.valid, stall_o});
        end
        tick();
        // Flush in IDLE drops the instruction outright.
        ex = rand_ex(1'($urandom), 1'b1);
        flush = 1'b1;
        #1;
        checks++;
        if ({dreq.valid, dataM.valid, stall_o} !== 3'b000) begin
            errors++; $display("FAIL flush_idle got %b exp 000", {dreq.valid, dataM.valid, stall_o});
        end
        tick();
        idle_inputs();
        // Flush in DONE drops the latched result.
        ex = rand_ex(1'b1, 1'b1);
        dresp.data_ok = 1'b1;
        stall_i = 1'b1;
        tick();
        dresp.data_ok = 1'b0;
        flush = 1'b1;
        #1;
        checks++;
        if ({dataM.valid, stall_o} !== 2'b00) begin
            errors++; $display("FAIL flush_done got %b exp 00", {dataM.valid, stall_o});
        end
        tick();
        idle_inputs();
        stall_i = 1'b1;
        #1;
        checks++;
        if ({dataM.valid, stall_o} !== 2'b00) begin
            errors++; $display("FAIL flush_done_after got %b exp 00", {dataM.valid, stall_o});
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_rst_wait();
        ex = rand_ex(1'b1, 1'b1);
        #1;
        checks++; if (dreq.valid !== 1'b1) begin errors++; $display("FAIL rstw_issue got %0b exp 1", dreq.valid); end
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({dreq.valid, dataM.valid, stall_o} !== 3'b000) begin
            errors++; $display("FAIL rstw_in_rst got %b exp 000", {dreq.valid, dataM.valid, stall_o});
        end
        tick();
        rst = 1'b0;
        ex.valid = 1'b0;
        dresp.data_ok = 1'b1;
        dresp.data = {$urandom, $urandom};
        #1;
        checks++;
        if ({dreq.valid, dataM.valid, stall_o} !== 3'b000) begin
            errors++; $display("FAIL rstw_stray_ok got %b exp 000", {dreq.valid, dataM.valid, stall_o});
        end
        tick();
        idle_inputs();
        do_mem(rand_ex(1'b1, 1'b1), 1, {$urandom, $urandom}, 0, "rstw_next");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_mem(rand_ex(1'($urandom), ($urandom % 4) != 0), int'($urandom_range(0, 4)),
                   {$urandom, $urandom}, int'($urandom_range(0, 2)), "random");
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            do_mem(rand_ex(1'($urandom), 1'b1), 0, {$urandom, $urandom}, 0, "b2b");
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_directed();
        test_misalign();
        test_flush();
        test_rst_wait();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock; rst  in  1  synchronous active-high reset, sampled on posedge clk.
REQ-002 SHALL have dataE_nxt  in  execute_data_t  EX/MEM register output (valid, is_load, is_store, size[1:0], sign_ext, addr[63:0], wdata[63:0], pass-through fields).
REQ-003 SHALL have flush  in  1  discard current instruction; stall_i  in  1  downstream (MEM/WB) not accepting.
REQ-004 SHALL have dreq  out  dbus_req_t  (valid, addr[63:0], size[2:0], strobe[7:0], data[63:0]); dresp  in  dbus_resp_t  (addr_ok, data_ok, data[63:0]).
REQ-005 SHALL have dataM  out  memory_data_t  (valid, rdata[63:0], exc_misalign, pass-through fields); stall_o  out  1  hold EX/MEM (drives its en low).

Function
REQ-006 SHALL use FSM states IDLE, WAIT, DONE; reset state IDLE.
REQ-007 IDLE: valid non-memory instruction SHALL pass to dataM combinationally, stall_o=0, no bus request.
REQ-008 IDLE: valid load/store SHALL assert dreq.valid in the same cycle, set stall_o=1, go to WAIT unless data_ok arrives that cycle (then go to DONE if stall_i, else stay IDLE with result emitted).
REQ-009 WAIT: dreq.valid and all dreq fields SHALL stay constant until the cycle data_ok=1; addr_ok SHALL be ignored for sequencing.
REQ-010 On data_ok: if stall_i=0, emit dataM.valid=1 that cycle, deassert stall_o, go to IDLE; if stall_i=1, latch result, go to DONE.
REQ-011 DONE: dreq.valid=0; dataM SHALL present latched result; stall_o=1 until stall_i=0, then IDLE.
REQ-012 Store: strobe = size mask (1/2/4/8 bytes for size 0..3) shifted left by addr[2:0]; dreq.data = wdata shifted left by 8*addr[2:0].
REQ-013 Load: rdata = dresp.data shifted right by 8*addr[2:0], truncated to size, sign- or zero-extended per sign_ext; stores SHALL give rdata=0.
REQ-014 dreq.size SHALL equal {1'b0,size}; dreq.addr SHALL equal addr unmodified.
REQ-015 flush in IDLE or DONE SHALL drop the instruction (dataM.valid=0), return to IDLE, stall_o=0.
REQ-016 flush in WAIT SHALL NOT drop dreq.valid; FSM SHALL remember a kill flag, wait for data_ok, discard result, then IDLE; stall_o stays 1 until data_ok.
REQ-017 Latency: zero added cycles for non-memory ops; memory ops complete in the data_ok cycle.

Reset
REQ-018 rst SHALL force state IDLE, kill flag 0, latched result 0; while rst=1 dreq.valid=0, dataM.valid=0, stall_o=0.
REQ-019 rst during WAIT SHALL abandon the transaction; any following data_ok SHALL be ignored.

Configuration
REQ-020 With MEM_MISALIGN_EXC_EN defined: addr not aligned to 2^size SHALL not issue dreq, SHALL emit dataM.valid=1 with exc_misalign=1 in the same cycle, no stall.
REQ-021 Without MEM_MISALIGN_EXC_EN: exc_misalign SHALL be tied 0 and misaligned accesses issue normally.

Structure
REQ-022 execute_data_t, memory_data_t SHALL live in package pipes; dbus_req_t, dbus_resp_t, size encodings and state enum SHALL live in package common.
REQ-023 Byte-lane shift/extend logic SHALL be a sub-module mem_align (combinational, strobe/wdata/rdata).

Verification
REQ-024 Load byte signed, addr=0x1003, dresp.data=0x00000000_80000000 at data_ok after 3 cycles -> stall_o=1 for 3 cycles, rdata=0xFFFFFFFF_FFFFFF80... (byte 3=0x80 sign-extended), dataM.valid=1 on data_ok cycle.
REQ-025 Store half, addr=0x2006, wdata=0xBEEF -> strobe=0xC0, dreq.data=0xBEEF0000_00000000, fields stable until data_ok.
REQ-026 Load dword, data_ok with stall_i=1 for 2 cycles -> DONE held 2 cycles, dataM stable, stall_o=1, then IDLE.
REQ-027 flush one cycle after load issue, data_ok 2 cycles later -> dreq.valid held, dataM.valid never 1, stall_o drops after data_ok.
REQ-028 rst asserted in WAIT, stray data_ok next cycle -> state IDLE, dataM.valid=0.
REQ-029 MEM_MISALIGN_EXC_EN defined, load word addr=0x1002 -> dreq.valid=0, exc_misalign=1, stall_o=0.
